// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: fill / read-back / compare sequencer for a write-every-cycle
// block RAM with a one-cycle registered read. Idle writes are parked on a
// reserved scratch word because the RAM has no write enable.
module mem_bist_ctrl #(
    parameter int unsigned WID_MEM   = 2,
    parameter int unsigned DEPTH_MEM = 32768,
    parameter int unsigned PARK_ADDR = DEPTH_MEM - 1,
    parameter int unsigned ERR_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               fill_en,
    input  logic [WID_MEM-1:0] seed,
    output logic [31:0]        mem_raddr,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [31:0]        first_err_addr,
    output logic [WID_MEM-1:0] first_err_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [31:0] PARK = 32'(PARK_ADDR);
    localparam logic [31:0] LAST = 32'(DEPTH_MEM - 2);

    state_t             state_q, state_n;
    logic [31:0]        addr_q, addr_n;
    logic [WID_MEM-1:0] seed_q, seed_n;
    logic               accept;

    // read pipeline: address presented last cycle, compared against dout now
    logic               pv_q;
    logic [31:0]        paddr_q;
    logic               mismatch;

    logic [31:0]        raddr_n, waddr_n;
    logic [WID_MEM-1:0] din_n;
    logic               pass_n;
    logic [ERR_W-1:0]   err_n;
    logic [31:0]        fea_n;
    logic [WID_MEM-1:0] fed_n;

    function automatic logic [WID_MEM-1:0] pattern(input logic [WID_MEM-1:0] a,
                                                   input logic [WID_MEM-1:0] s);
        return a ^ s;
    endfunction

    // next-state, address counter and seed capture
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        seed_n  = seed_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    seed_n  = seed;
                    addr_n  = '0;
                    state_n = fill_en ? S_FILL : S_READ;
                end
            end
            S_FILL: begin
                if (addr_q == LAST) begin
                    state_n = S_READ;
                    addr_n  = '0;
                end else begin
                    addr_n = addr_q + 32'd1;
                end
            end
            S_READ: begin
                if (addr_q == LAST) state_n = S_DRAIN;
                else                addr_n  = addr_q + 32'd1;
            end
            S_DRAIN: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // RAM port values for the coming cycle, derived from the coming state so
    // the registered ports line up with the state register
    always_comb begin
        raddr_n = PARK;
        waddr_n = PARK;
        din_n   = '0;
        if (state_n == S_FILL) begin
            waddr_n = addr_n;
            din_n   = pattern(addr_n[WID_MEM-1:0], seed_n);
        end else if (state_n == S_READ) begin
            raddr_n = addr_n;
        end
    end

    assign mismatch = pv_q && (mem_dout != pattern(paddr_q[WID_MEM-1:0], seed_q));

    // error accounting; pass includes the final compare made in DRAIN
    always_comb begin
        err_n  = err_count;
        fea_n  = first_err_addr;
        fed_n  = first_err_data;
        pass_n = pass;
        if (accept) begin
            err_n  = '0;
            fea_n  = '0;
            fed_n  = '0;
            pass_n = 1'b0;
        end else begin
            if (mismatch) begin
                if (err_count != '1) err_n = err_count + 1'b1;
                if (err_count == '0) begin
                    fea_n = paddr_q;
                    fed_n = mem_dout;
                end
            end
            if (state_q == S_DRAIN) pass_n = (err_n == '0);
        end
    end

    // all registered state and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            seed_q         <= '0;
            pv_q           <= 1'b0;
            paddr_q        <= '0;
            mem_raddr      <= PARK;
            mem_waddr      <= PARK;
            mem_din        <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            state_q        <= state_n;
            addr_q         <= addr_n;
            seed_q         <= seed_n;
            pv_q           <= (state_q == S_READ);
            paddr_q        <= addr_q;
            mem_raddr      <= raddr_n;
            mem_waddr      <= waddr_n;
            mem_din        <= din_n;
            pass           <= pass_n;
            err_count      <= err_n;
            first_err_addr <= fea_n;
            first_err_data <= fed_n;
        end
    end

    assign busy = (state_q == S_FILL) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with DEPTH_MEM=16, WID_MEM=2. A second
// instance with ERR_W=3 runs on identical stimulus with its own RAM model.
module tb_mem_bist_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, fill_en;
    logic [1:0]  seed;

    logic [31:0] raddr1, waddr1, fea1, raddr2, waddr2, fea2;
    logic [1:0]  din1, dout1, fed1, din2, dout2, fed2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] err1;
    logic [2:0]  err2;

    logic [1:0]  ram1 [16];
    logic [1:0]  ram2 [16];
    logic        bd_en = 1'b0;
    logic [3:0]  bd_addr = '0;
    logic [1:0]  bd_data = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int dc, dcount, dfirst, dsecond;
    logic b33, b34;

    always #5 clk = ~clk;

    mem_bist_ctrl #(.WID_MEM(2), .DEPTH_MEM(16), .ERR_W(16)) dut1 (
        .clk(clk), .reset(reset), .start(start), .fill_en(fill_en), .seed(seed),
        .mem_raddr(raddr1), .mem_waddr(waddr1), .mem_din(din1), .mem_dout(dout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_addr(fea1), .first_err_data(fed1));

    mem_bist_ctrl #(.WID_MEM(2), .DEPTH_MEM(16), .ERR_W(3)) dut2 (
        .clk(clk), .reset(reset), .start(start), .fill_en(fill_en), .seed(seed),
        .mem_raddr(raddr2), .mem_waddr(waddr2), .mem_din(din2), .mem_dout(dout2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_addr(fea2), .first_err_data(fed2));

    // RAM models: write every cycle, one-cycle registered read, backdoor write
    always @(posedge clk) begin
        ram1[waddr1[3:0]] <= din1;
        ram2[waddr2[3:0]] <= din2;
        dout1 <= ram1[raddr1[3:0]];
        dout2 <= ram2[raddr2[3:0]];
        if (bd_en) begin
            ram1[bd_addr] <= bd_data;
            ram2[bd_addr] <= bd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // launch a run from an IDLE negedge; returns the done cycle (-1 on timeout)
    // and leaves the bench at the following IDLE cycle
    task automatic run(input logic f, input logic [1:0] s, output int dcyc);
        start = 1'b1; fill_en = f; seed = s;
        tick();
        start = 1'b0;
        dcyc = -1;
        for (int c = 1; c < 200; c++) begin
            if (done1) begin
                dcyc = c;
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; fill_en = 1'b0; seed = '0;
        tick(); tick();
        check("rst_raddr", raddr1, 32'd15);
        check("rst_waddr", waddr1, 32'd15);
        check("rst_din",   din1, 0);
        check("rst_busy",  busy1, 0);
        check("rst_done",  done1, 0);
        check("rst_pass",  pass1, 0);
        check("rst_err",   err1, 0);
        check("rst_fea",   fea1, 0);
        check("rst_fed",   fed1, 0);
        reset = 1'b0;
        tick();

        // fill + verify, seed 01
        run(1'b1, 2'b01, dc);
        check("t1_done_cycle", dc, 32);
        check("t1_pass", pass1, 1);
        check("t1_err",  err1, 0);
        check("t1_pass_e3", pass2, 1);
        for (int a = 0; a < 15; a++)
            check("t1_ram", ram1[a], a[1:0] ^ 2'b01);
        check("t1_ram_park", ram1[15], 0);

        // verify-only with the wrong seed
        run(1'b0, 2'b11, dc);
        check("t2_done_cycle", dc, 17);
        check("t2_err",  err1, 15);
        check("t2_pass", pass1, 0);
        check("t2_fea",  fea1, 0);
        check("t2_fed",  fed1, 2'b01);
        check("t2_err_sat", err2, 7);
        check("t2_pass_e3", pass2, 0);
        tick(); tick();
        check("t2_err_stable", err1, 15);

        // single corrupted word
        run(1'b1, 2'b00, dc);
        check("t3_fill_pass", pass1, 1);
        bd_en = 1'b1; bd_addr = 4'd7; bd_data = 2'b00;
        tick();
        bd_en = 1'b0;
        run(1'b0, 2'b00, dc);
        check("t3_done_cycle", dc, 17);
        check("t3_err", err1, 1);
        check("t3_fea", fea1, 7);
        check("t3_fed", fed1, 2'b00);
        check("t3_pass", pass1, 0);

        // reset during FILL cycle 5
        start = 1'b1; fill_en = 1'b1; seed = 2'b10;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        check("t4_busy_pre", busy1, 1);
        check("t4_waddr_pre", waddr1, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_raddr", raddr1, 32'd15);
        check("t4_waddr", waddr1, 32'd15);
        check("t4_din",   din1, 0);
        check("t4_busy",  busy1, 0);
        check("t4_done",  done1, 0);
        check("t4_err",   err1, 0);
        check("t4_fea",   fea1, 0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (done1) dcount++;
            tick();
        end
        check("t4_no_done", dcount, 0);
        run(1'b1, 2'b10, dc);
        check("t4_rerun_cycle", dc, 32);
        check("t4_rerun_pass", pass1, 1);

        // start pulses mid-run are ignored; held start relaunches after DONE
        start = 1'b1; fill_en = 1'b1; seed = 2'b01;
        tick();
        dcount = 0; dfirst = -1; dsecond = -1; b33 = 1'b0; b34 = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            if (done1) begin
                dcount++;
                if (dfirst < 0) dfirst = c;
                else            dsecond = c;
            end
            if (c == 33) b33 = busy1;
            if (c == 34) b34 = busy1;
            start = (c == 3) || (c >= 31 && c < 34);
            tick();
        end
        check("t5_done_count", dcount, 2);
        check("t5_first_done", dfirst, 32);
        check("t5_idle_gap",   b33, 0);
        check("t5_relaunch",   b34, 1);
        check("t5_second_done", dsecond, 65);
        check("t5_pass", pass1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
